// File: rtl/am_demod_env.sv
// am_demod_env: full-wave rectifying AM envelope detector with box-car
// decimation, DC-removed audio output and hysteretic carrier detect.
module am_demod_env #(
  parameter int unsigned W  = 16,
  parameter int unsigned L  = 4,
  parameter int unsigned K  = 4,
  parameter int unsigned VT = 1000,
  parameter int unsigned VH = 200
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] env,
  output logic [W-1:0] audio,
  output logic         carrier
);

  localparam int unsigned AW      = W + L;
  localparam int unsigned THR_ON  = VT + VH;
  localparam int unsigned THR_OFF = VT - VH;

  typedef enum logic {
    NOC = 1'b0,
    CAR = 1'b1
  } car_state_e;

  logic [AW-1:0]  acc_q, acc_d;
  logic [L-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   dc_q, dc_d;
  logic [W-1:0]   env_q, env_d;
  logic [W-1:0]   audio_q, audio_d;
  logic           out_valid_q, out_valid_d;
  car_state_e     state_q, state_d;

  logic           accept;
  logic           blk_done;
  logic [W-1:0]   mag;
  logic [AW-1:0]  sum;
  logic [W-1:0]   avg;
  logic signed [W:0] diff;
  logic signed [W:0] dc_step;
  logic [W-1:0]   diff_sat;

  // Rectify, accumulate, and on the last sample of a block update the results
  always_comb begin
    in_ready    = !out_valid_q || out_ready;
    accept      = in_valid && in_ready;
    // Magnitude of the most negative sample is 2^(W-1), which fits unsigned W bits
    mag         = in_data[W-1] ? W'(~in_data + W'(1)) : in_data;
    sum         = acc_q + AW'(mag);
    blk_done    = accept && (&cnt_q);
    avg         = W'(sum >> L);
    diff        = $signed({1'b0, avg}) - $signed({1'b0, dc_q});
    dc_step     = diff >>> K;
    // diff only leaves the W-bit signed range when its top two bits disagree
    if (diff[W] != diff[W-1]) begin
      diff_sat = diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      diff_sat = diff[W-1:0];
    end

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dc_d        = dc_q;
    env_d       = env_q;
    audio_d     = audio_q;
    out_valid_d = out_valid_q && !out_ready;

    if (accept) begin
      if (blk_done) begin
        acc_d       = '0;
        cnt_d       = '0;
        env_d       = avg;
        audio_d     = diff_sat;
        dc_d        = W'($signed({1'b0, dc_q}) + dc_step);
        out_valid_d = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + L'(1);
      end
    end
  end

  // Carrier-detect next state, evaluated only when a block completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      NOC: if (blk_done && (32'(avg) > THR_ON))  state_d = CAR;
      CAR: if (blk_done && (32'(avg) < THR_OFF)) state_d = NOC;
      default: state_d = NOC;
    endcase
  end

  // Carrier-detect state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= NOC;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      dc_q        <= '0;
      env_q       <= '0;
      audio_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dc_q        <= dc_d;
      env_q       <= env_d;
      audio_q     <= audio_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign env       = env_q;
  assign audio     = audio_q;
  assign carrier   = (state_q == CAR);

endmodule

// File: tb/tb_am_demod_env.sv
// Directed bench for am_demod_env with default parameters (DEC = 16, K = 4).
module tb_am_demod_env;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] env;
  logic [15:0] audio;
  logic        carrier;

  int n_checks = 0;
  int n_fail   = 0;

  am_demod_env dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .env       (env),
    .audio     (audio),
    .carrier   (carrier)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present n samples, one per cycle; alt flips the sign of every odd sample
  task automatic send_block(input logic signed [15:0] v, input int n, input bit alt);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = (alt && i[0]) ? 16'(-v) : v;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int          hv   [5] = '{1100, 1300, 900, 700, 0};
  logic [15:0] ha   [5] = '{16'd1100, 16'd1232, 16'd755, 16'd508, 16'hFF21};
  logic        hc   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_env",       32'(env), 0);
    chk("rst_audio",     32'(audio), 0);
    chk("rst_carrier",   32'(carrier), 0);
    chk("rst_in_ready",  32'(in_ready), 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Constant -3000: envelope 3000, dc becomes 187
    send_block(-16'sd3000, 16, 1'b0);
    chk("b1_out_valid", 32'(out_valid), 1);
    chk("b1_env",       32'(env), 3000);
    chk("b1_audio",     32'(audio), 3000);
    chk("b1_carrier",   32'(carrier), 1);
    @(negedge clk);
    chk("b1_valid_drop", 32'(out_valid), 0);
    chk("b1_env_hold",   32'(env), 3000);

    // Backpressure: result pending, input must stall
    out_ready = 1'b0;
    send_block(-16'sd3000, 16, 1'b0);
    chk("b2_out_valid", 32'(out_valid), 1);
    chk("b2_audio",     32'(audio), 2813);
    in_valid = 1'b1;
    in_data  = 16'd5000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready",  32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_env",       32'(env), 3000);
      chk("bp_audio",     32'(audio), 2813);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 1);
    @(negedge clk);
    chk("bp_taken", 32'(out_valid), 0);

    // No stalled sample was consumed: block completes after exactly 16 more
    send_block(-16'sd3000, 15, 1'b0);
    chk("b3_early", 32'(out_valid), 0);
    send_block(-16'sd3000, 1, 1'b0);
    chk("b3_out_valid", 32'(out_valid), 1);
    chk("b3_audio",     32'(audio), 2638);
    @(negedge clk);

    // Reset mid-block clears outputs asynchronously and drops partial sum
    send_block(16'sd5000, 7, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_env",       32'(env), 0);
    chk("mid_rst_audio",     32'(audio), 0);
    chk("mid_rst_carrier",   32'(carrier), 0);
    chk("mid_rst_in_ready",  32'(in_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    send_block(16'sd2000, 15, 1'b0);
    chk("b4_early", 32'(out_valid), 0);
    send_block(16'sd2000, 1, 1'b0);
    chk("b4_out_valid", 32'(out_valid), 1);
    chk("b4_env",       32'(env), 2000);
    chk("b4_audio",     32'(audio), 2000);
    chk("b4_carrier",   32'(carrier), 1);
    @(negedge clk);

    // Most negative input: full-scale envelope, saturated audio
    pulse_reset();
    send_block(16'sh8000, 16, 1'b0);
    chk("fs_out_valid", 32'(out_valid), 1);
    chk("fs_env",       32'(env), 32768);
    chk("fs_audio",     32'(audio), 32767);
    chk("fs_carrier",   32'(carrier), 1);
    @(negedge clk);

    // Hysteresis with alternating-sign carrier; last block drives audio negative
    pulse_reset();
    for (int b = 0; b < 5; b++) begin
      send_block(16'(hv[b]), 16, 1'b1);
      chk("hy_out_valid", 32'(out_valid), 1);
      chk("hy_env",       32'(env), 32'(hv[b]));
      chk("hy_audio",     32'(audio), 32'(ha[b]));
      chk("hy_carrier",   32'(carrier), 32'(hc[b]));
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/am_demod_env.md
# am_demod_env

Sampled-data AM demodulator: the receive-side counterpart to the AM modulator source used in the mixed-signal models. It accepts signed carrier samples over a valid/ready stream and full-wave rectifies them. Blocks of `DEC` samples are box-car averaged to recover the envelope. The block also produces a DC-removed audio output and a hysteretic carrier-detect flag, so it can sit between an ADC model and downstream digital audio logic in co-simulation benches.

## Interface
- `W`, 16: input sample width, signed two's complement.
- `L`, 4: log2 of the decimation factor; `DEC = 2**L` samples per output.
- `K`, 4: DC-tracker shift; the loop gain is 2^-K.
- `VT`, 1000: carrier-detect threshold, unsigned envelope units.
- `VH`, 200: carrier-detect hysteresis half-width. Requires `VT > VH`.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1  `in_data` holds a sample.
- `in_ready`  out  1  block can accept a sample this cycle.
- `in_data`  in  W  signed carrier sample.
- `out_valid`  out  1  `env`/`audio` hold a new result.
- `out_ready`  in  1  consumer accepts the result this cycle.
- `env`  out  W  unsigned envelope (block average of |x|).
- `audio`  out  W  signed envelope minus tracked DC, saturated.
- `carrier`  out  1  carrier-present flag, with hysteresis.

## Operation
- Accept: a sample is taken on an edge where `in_valid && in_ready`.
- Flow control: `in_ready = !out_valid || out_ready`. The input stalls whenever a result is pending and not being taken.
- Rectify: `a = |in_data|` as W-bit unsigned. For -2^(W-1), `a = 2^(W-1)`; there is no wrap.
- Accumulator `acc` (W+L bits, unsigned) and sample counter `cnt` (L bits):
  - Samples 0..DEC-2 of a block: `acc <= acc + a`, `cnt <= cnt + 1`.
  - Sample DEC-1: `sum = acc + a`, `avg = sum >> L` (truncating; fits W bits). Then `acc <= 0` and `cnt <= 0`, which wraps.
- Result update, on the same edge as sample DEC-1:
  - `env <= avg`.
  - `diff = avg - dc`, computed as W+1-bit signed.
  - `audio <= sat_W(diff)`, clamped to [-2^(W-1), 2^(W-1)-1].
  - `dc <= dc + (diff >>> K)`: arithmetic shift, rounds toward -inf. `dc` is W-bit unsigned and stays within [0, 2^(W-1)].
  - `out_valid <= 1`.
- Output handshake:
  - `out_valid` stays high, and `env`/`audio`/`carrier` stay stable, until an edge where `out_ready` is high.
  - On that edge `out_valid` clears, unless the same edge also completes a new block. In that case it stays 1 and the new values load (back-to-back).
- Carrier FSM, evaluated only on block completion using `avg`, with states NOC and CAR:
  - NOC -> CAR when `avg > VT+VH`.
  - CAR -> NOC when `avg < VT-VH`.
  - Otherwise the state holds.
  - `carrier = (state == CAR)`, registered and updated together with `env`.
- Reset values: `out_valid` 0, `env` 0, `audio` 0, `carrier` 0 (NOC), `acc` 0, `cnt` 0, `dc` 0. `in_ready` is therefore 1 during and after reset.
- Reset mid-block discards the partial accumulation. The next accepted sample is sample 0 of a new block.

## Timing
- Latency: `out_valid` rises in the cycle after the edge that accepts sample DEC-1. All outputs are registered.
- Throughput: one sample per cycle with `out_ready` tied high. Block spacing is DEC accepted samples.
- `in_valid` low cycles do not advance `cnt`; gaps are allowed anywhere.
- `in_ready` is combinational from `out_valid` and `out_ready`. There is no combinational path from `in_valid`.
- There is no path from `reset` to outputs other than the asynchronous clear.

## Test plan
- Reset, with default params: assert `reset` mid-stream. Required: `out_valid=0`, `env=0`, `audio=0`, `carrier=0`, `in_ready=1` immediately, without waiting for a clock edge.
- 16 samples of -3000, `out_ready=1`: `out_valid` pulses 1 cycle after the 16th accept with `env=3000`, `audio=3000`, `carrier=1`. Internal `dc` becomes 187.
- 16 samples of -32768 from reset: `env=32768`, `audio=32767` (saturated), with no overflow in `acc`.
- Backpressure: hold `out_ready=0` after a result. Required: `in_ready=0`, no samples consumed, outputs stable for 10 cycles. Raise `out_ready`: the result is taken and `in_ready` returns to 1 on the same cycle.
- Hysteresis: successive blocks of constant magnitude 1100, 1300, 900, 700 give `carrier` = 0, 1, 1, 0.
- Reset after 7 of 16 samples of 5000, then 16 samples of 2000: the single result is `env=2000`, with no contribution from the 5000s.
